rx_polling_monitor: RTL and testbench

RX_POLLING_MONITOR -- requirements
Module: rx_polling_monitor

---
 rtl/rx_polling_monitor.sv | 131 +++++++++++++
 tb/tb_rx_polling_monitor.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/rx_polling_monitor.sv
// RX polling monitor: counts consecutive qualifying training sets in Polling.Active/Configuration and requests the next Rx substate.
// Latency: finishRx/gotoRx rise one cycle after the completing training set; all outputs are registered.
// Backpressure: none, every tsValid strobe is consumed; define RX_POLL_TIMEOUT_EN for the per-substate fallback timer.
module rx_polling_monitor #(
    parameter int TS_COUNT       = 8,
    parameter int TIMEOUT_CYCLES = 24000,
    parameter int CNT_W          = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] substateRx,
    input  logic       tsValid,
    input  logic       tsType,
    input  logic       tsLinkPad,
    input  logic       tsLanePad,
    output logic       finishRx,
    output logic [3:0] gotoRx,
    output logic [3:0] tsCount
);

    if (TS_COUNT < 1 || TS_COUNT > 15 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (1 << CNT_W)) begin : gBadParams
        $error("rx_polling_monitor: TS_COUNT must fit tsCount and CNT_W must hold TIMEOUT_CYCLES");
    end

    localparam logic [3:0] TS_MAX = 4'(TS_COUNT);

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t     state, stateNext;
    logic [3:0] tracked, trackedNext;
    logic       finishNext;
    logic [3:0] gotoNext, countNext;
    logic       inPolling, qualify;

`ifdef RX_POLL_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] timer, timerNext;
`endif

    assign inPolling = (substateRx == 4'd2) || (substateRx == 4'd3);
    // Polling.Active accepts TS1 or TS2; Polling.Configuration only TS2.
    assign qualify   = tsValid && tsLinkPad && tsLanePad && ((tracked == 4'd2) || tsType);

    always_comb begin
        stateNext   = state;
        trackedNext = tracked;
        finishNext  = finishRx;
        gotoNext    = gotoRx;
        countNext   = tsCount;
`ifdef RX_POLL_TIMEOUT_EN
        timerNext   = timer;
`endif
        case (state)
            IDLE: begin
                finishNext = 1'b0;
                gotoNext   = 4'd0;
                countNext  = 4'd0;
`ifdef RX_POLL_TIMEOUT_EN
                timerNext  = '0;
`endif
                if (inPolling) begin
                    stateNext   = COUNT;
                    trackedNext = substateRx;
                end
            end
            COUNT: begin
`ifdef RX_POLL_TIMEOUT_EN
                timerNext = timer + 1'b1;
`endif
                if (substateRx != tracked) begin
                    stateNext = IDLE;
                    countNext = 4'd0;
`ifdef RX_POLL_TIMEOUT_EN
                    timerNext = '0;
`endif
                end else if (qualify && (tsCount == TS_MAX - 4'd1)) begin
                    // Success takes priority over a coincident timeout.
                    stateNext  = DONE;
                    countNext  = TS_MAX;
                    finishNext = 1'b1;
                    gotoNext   = (tracked == 4'd3) ? 4'd4 : 4'd3;
                end else begin
                    if (qualify) begin
                        countNext = (tsCount == TS_MAX) ? tsCount : tsCount + 4'd1;
                    end else if (tsValid) begin
                        countNext = 4'd0;
                    end
`ifdef RX_POLL_TIMEOUT_EN
                    if (timer == TIMER_LAST) begin
                        stateNext  = DONE;
                        finishNext = 1'b1;
                        gotoNext   = 4'd0;
                    end
`endif
                end
            end
            DONE: begin
                if (substateRx != tracked) begin
                    stateNext  = IDLE;
                    finishNext = 1'b0;
                    gotoNext   = 4'd0;
                    countNext  = 4'd0;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            tracked  <= 4'd0;
            finishRx <= 1'b0;
            gotoRx   <= 4'd0;
            tsCount  <= 4'd0;
`ifdef RX_POLL_TIMEOUT_EN
            timer    <= '0;
`endif
        end else begin
            state    <= stateNext;
            tracked  <= trackedNext;
            finishRx <= finishNext;
            gotoRx   <= gotoNext;
            tsCount  <= countNext;
`ifdef RX_POLL_TIMEOUT_EN
            timer    <= timerNext;
`endif
        end
    end

endmodule

// File: tb/tb_rx_polling_monitor.sv
// Bench for rx_polling_monitor: directed polling scenarios plus random traffic, scored against a reference model.
module tb_rx_polling_monitor;

    localparam int TSN = 8;
    localparam int TMO = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] substateRx = 4'd0;
    logic       tsValid = 1'b0;
    logic       tsType = 1'b0;
    logic       tsLinkPad = 1'b0;
    logic       tsLanePad = 1'b0;
    logic       finishRx;
    logic [3:0] gotoRx;
    logic [3:0] tsCount;

    rx_polling_monitor #(.TS_COUNT(TSN), .TIMEOUT_CYCLES(TMO), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .substateRx(substateRx), .tsValid(tsValid), .tsType(tsType),
        .tsLinkPad(tsLinkPad), .tsLanePad(tsLanePad), .finishRx(finishRx), .gotoRx(gotoRx), .tsCount(tsCount)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       fin;
        logic [3:0] go;
        logic [3:0] cnt;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   failures = 0;

`ifdef RX_POLL_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    // Reference model: abstract view of the polling rules.
    bit tracking = 0;
    bit decided = 0;
    int trackedSub = 0;
    int streak = 0;
    int elapsed = 0;
    int expGoto = 0;
    bit expFin = 0;

    task automatic modelStep();
        bit q;
        if (!reset) begin
            tracking = 0; decided = 0; streak = 0; elapsed = 0; expFin = 0; expGoto = 0;
        end else if (!tracking) begin
            expFin = 0; expGoto = 0; streak = 0;
            if (substateRx == 2 || substateRx == 3) begin
                tracking = 1; decided = 0; trackedSub = int'(substateRx); elapsed = 0;
            end
        end else if (decided) begin
            if (int'(substateRx) != trackedSub) begin
                tracking = 0; expFin = 0; expGoto = 0; streak = 0;
            end
        end else if (int'(substateRx) != trackedSub) begin
            tracking = 0; streak = 0;
        end else begin
            q = tsValid && tsLinkPad && tsLanePad && (trackedSub == 2 || tsType);
            if (q) streak = (streak + 1 > TSN) ? TSN : streak + 1;
            else if (tsValid) streak = 0;
            if (q && streak == TSN) begin
                decided = 1; expFin = 1; expGoto = trackedSub + 1;
            end else if (TIMEOUT_ON && elapsed == TMO - 1) begin
                decided = 1; expFin = 1; expGoto = 0;
            end
            elapsed++;
        end
        expQ.push_back('{fin: expFin, go: 4'(expGoto), cnt: 4'(streak)});
    endtask

    task automatic step(input int sub, input bit v, input bit ty, input bit lk, input bit ln, input bit rst);
        @(negedge clk);
        reset = rst; substateRx = 4'(sub); tsValid = v; tsType = ty; tsLinkPad = lk; tsLanePad = ln;
        modelStep();
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic peek(output int f, output int g, output int c);
        @(posedge clk);
        #2;
        f = int'(finishRx); g = int'(gotoRx); c = int'(tsCount);
    endtask

    // Monitor: every clock the DUT presents its registered outputs; compare to the oldest expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checks++;
            if (finishRx !== e.fin || gotoRx !== e.go || tsCount !== e.cnt) begin
                failures++;
                $display("FAIL scoreboard @%0t: got fin=%0b goto=%0d cnt=%0d expected fin=%0b goto=%0d cnt=%0d",
                         $time, finishRx, gotoRx, tsCount, e.fin, e.go, e.cnt);
            end
        end
    end

    initial begin
        int f, g, c, sub;
        #1;
        chk("reset_finish", int'(finishRx), 0);
        chk("reset_goto", int'(gotoRx), 0);
        chk("reset_count", int'(tsCount), 0);
        repeat (3) step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);

        // Eight back-to-back TS1 in Polling.Active.
        step(2, 0, 0, 0, 0, 1);
        for (int i = 0; i < TSN; i++) step(2, 1, 0, 1, 1, 1);
        peek(f, g, c);
        chk("active_finish", f, 1);
        chk("active_goto", g, 3);

        // Leave DONE into Configuration, then 5 TS2, 1 TS1, 8 TS2.
        step(3, 0, 0, 0, 0, 1);
        peek(f, g, c);
        chk("done_exit_finish", f, 0);
        step(3, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            step(3, 1, 1, 1, 1, 1);
            step(3, 0, 0, 0, 0, 1);
        end
        step(3, 1, 0, 1, 1, 1);
        peek(f, g, c);
        chk("cfg_ts1_clears", c, 0);
        for (int i = 0; i < TSN; i++) step(3, 1, 1, 1, 1, 1);
        peek(f, g, c);
        chk("cfg_finish", f, 1);
        chk("cfg_goto", g, 4);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);

        // Silence for the whole window.
        step(2, 0, 0, 0, 0, 1);
        for (int i = 0; i < TMO; i++) step(2, 0, 0, 0, 0, 1);
        peek(f, g, c);
        chk("timeout_finish", f, TIMEOUT_ON ? 1 : 0);
        chk("timeout_goto", g, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);

        // Eighth TS lands on the last timer cycle: success wins.
        step(2, 0, 0, 0, 0, 1);
        for (int i = 0; i < TMO; i++) step(2, i >= TMO - TSN, 0, 1, 1, 1);
        peek(f, g, c);
        chk("boundary_finish", f, 1);
        chk("boundary_goto", g, 3);
        step(0, 0, 0, 0, 0, 1);

        // Reset after four TS; a full new count is required.
        step(2, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(2, 1, 0, 1, 1, 1);
        step(2, 0, 0, 0, 0, 0);
        #1;
        chk("async_reset_count", int'(tsCount), 0);
        chk("async_reset_finish", int'(finishRx), 0);
        step(2, 0, 0, 0, 0, 0);
        step(2, 0, 0, 0, 0, 1);
        for (int i = 0; i < TSN - 1; i++) step(2, 1, 0, 1, 1, 1);
        peek(f, g, c);
        chk("post_reset_count", c, TSN - 1);
        chk("post_reset_finish", f, 0);
        step(2, 1, 1, 1, 1, 1);
        peek(f, g, c);
        chk("post_reset_done", f, 1);

        // Abort mid-count: no finish pulse.
        step(0, 0, 0, 0, 0, 1);
        step(2, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(2, 1, 0, 1, 1, 1);
        step(3, 0, 0, 0, 0, 1);
        peek(f, g, c);
        chk("abort_finish", f, 0);
        chk("abort_count", c, 0);

        // Random traffic.
        sub = 2;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 59) == 0) sub = $urandom_range(0, 3);
            step(sub, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 19) != 0, $urandom_range(0, 19) != 0,
                 $urandom_range(0, 499) != 0);
        end

        repeat (3) @(posedge clk);
        #3;
        chk("queue_drained", expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1);
    end

endmodule
